// File: rtl/triangle_normal.sv
// triangle_normal: un-normalized face normal (v1-v0) x (v2-v0) in signed
// fixed point. One multiplier is shared across six cycles.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  vertex-triple handshake; ready only in IDLE and not in reset
//   v0, v1, v2      triangle vertices, captured on accept
//   out_valid/ready result handshake; result is held until taken
//   normal          saturated cross product
//   out_overflow    some intermediate or final value saturated
//   out_degenerate  normal is exactly zero and no overflow occurred

package fixed_point;
   localparam int FIXED_W          = 16;
   localparam int FIXED_FRACTION_W = 8;
   typedef logic signed [FIXED_W-1:0] fixed_point_t;
endpackage

package vector;
   import fixed_point::*;
   typedef struct packed {
      fixed_point_t x;
      fixed_point_t y;
      fixed_point_t z;
   } vector_t;
endpackage

module triangle_normal
   import fixed_point::*;
   import vector::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    in_valid,
   output logic    in_ready,
   input  vector_t v0,
   input  vector_t v1,
   input  vector_t v2,
   output logic    out_valid,
   input  logic    out_ready,
   output vector_t normal,
   output logic    out_overflow,
   output logic    out_degenerate
);

   localparam int W = FIXED_W;
   localparam int F = FIXED_FRACTION_W;
   localparam fixed_point_t FMAX = {1'b0, {(W-1){1'b1}}};
   localparam fixed_point_t FMIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_EDGE, S_MUL, S_SUB, S_DONE} state_t;

   // Saturating subtract; returns {overflow, result}.
   function automatic logic [W:0] sat_sub(input fixed_point_t a, input fixed_point_t b);
      logic [W:0] d;
      d = {a[W-1], a} - {b[W-1], b};
      if (d[W] != d[W-1]) return {1'b1, (d[W] ? FMIN : FMAX)};
      return {1'b0, d[W-1:0]};
   endfunction

   state_t              state_q;
   logic [2:0]          cnt_q;
   logic                ovf_q;
   vector_t             v0_q, v1_q, v2_q;
   vector_t             e1_q, e2_q;
   fixed_point_t [5:0]  p_q;
   vector_t             normal_q;
   logic                out_valid_q, out_overflow_q, out_degenerate_q;

   // ---------------- edge vectors ----------------
   logic [W:0] ex1_d, ey1_d, ez1_d, ex2_d, ey2_d, ez2_d;
   logic       edge_ovf_d;
   always_comb begin
      ex1_d = sat_sub(v1_q.x, v0_q.x);
      ey1_d = sat_sub(v1_q.y, v0_q.y);
      ez1_d = sat_sub(v1_q.z, v0_q.z);
      ex2_d = sat_sub(v2_q.x, v0_q.x);
      ey2_d = sat_sub(v2_q.y, v0_q.y);
      ez2_d = sat_sub(v2_q.z, v0_q.z);
      edge_ovf_d = ex1_d[W] | ey1_d[W] | ez1_d[W] | ex2_d[W] | ey2_d[W] | ez2_d[W];
   end

   // ---------------- shared multiplier ----------------
   fixed_point_t        opa_d, opb_d;
   logic [2*W-1:0]      prod_full_d;
   logic signed [2*W-1:0] prod_sh_d;
   logic                mul_ovf_d;
   fixed_point_t        mul_res_d;
   always_comb begin
      opa_d = '0;
      opb_d = '0;
      case (cnt_q)
         3'd0: begin opa_d = e1_q.y; opb_d = e2_q.z; end
         3'd1: begin opa_d = e1_q.z; opb_d = e2_q.y; end
         3'd2: begin opa_d = e1_q.z; opb_d = e2_q.x; end
         3'd3: begin opa_d = e1_q.x; opb_d = e2_q.z; end
         3'd4: begin opa_d = e1_q.x; opb_d = e2_q.y; end
         3'd5: begin opa_d = e1_q.y; opb_d = e2_q.x; end
         default: ;
      endcase
      // Sign-extended operands make the low 2W bits of the unsigned product
      // equal the two's-complement signed product.
      prod_full_d = {{W{opa_d[W-1]}}, opa_d} * {{W{opb_d[W-1]}}, opb_d};
      prod_sh_d   = $signed(prod_full_d) >>> F;
      // Fits in W bits only if the top W+1 bits are all equal.
      mul_ovf_d   = !((&prod_sh_d[2*W-1:W-1]) || !(|prod_sh_d[2*W-1:W-1]));
      mul_res_d   = mul_ovf_d ? (prod_sh_d[2*W-1] ? FMIN : FMAX) : prod_sh_d[W-1:0];
   end

   // ---------------- final subtract ----------------
   logic [W:0] nx_d, ny_d, nz_d;
   logic       ovf_fin_d;
   always_comb begin
      nx_d      = sat_sub(p_q[0], p_q[1]);
      ny_d      = sat_sub(p_q[2], p_q[3]);
      nz_d      = sat_sub(p_q[4], p_q[5]);
      ovf_fin_d = ovf_q | nx_d[W] | ny_d[W] | nz_d[W];
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         ovf_q            <= 1'b0;
         v0_q             <= '0;
         v1_q             <= '0;
         v2_q             <= '0;
         e1_q             <= '0;
         e2_q             <= '0;
         p_q              <= '0;
         normal_q         <= '0;
         out_valid_q      <= 1'b0;
         out_overflow_q   <= 1'b0;
         out_degenerate_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  v0_q    <= v0;
                  v1_q    <= v1;
                  v2_q    <= v2;
                  state_q <= S_EDGE;
               end
            end
            S_EDGE: begin
               e1_q    <= '{x: ex1_d[W-1:0], y: ey1_d[W-1:0], z: ez1_d[W-1:0]};
               e2_q    <= '{x: ex2_d[W-1:0], y: ey2_d[W-1:0], z: ez2_d[W-1:0]};
               ovf_q   <= ovf_q | edge_ovf_d;
               cnt_q   <= '0;
               state_q <= S_MUL;
            end
            S_MUL: begin
               p_q[cnt_q] <= mul_res_d;
               ovf_q      <= ovf_q | mul_ovf_d;
               if (cnt_q == 3'd5) begin
                  cnt_q   <= '0;
                  state_q <= S_SUB;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            S_SUB: begin
               normal_q         <= '{x: nx_d[W-1:0], y: ny_d[W-1:0], z: nz_d[W-1:0]};
               ovf_q            <= ovf_fin_d;
               out_overflow_q   <= ovf_fin_d;
               out_degenerate_q <= (nx_d[W-1:0] == '0) && (ny_d[W-1:0] == '0) &&
                                   (nz_d[W-1:0] == '0) && !ovf_fin_d;
               out_valid_q      <= 1'b1;
               state_q          <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  ovf_q       <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready       = (state_q == S_IDLE) && !rst;
   assign out_valid      = out_valid_q;
   assign normal         = normal_q;
   assign out_overflow   = out_overflow_q;
   assign out_degenerate = out_degenerate_q;

endmodule

// File: tb/tb_triangle_normal.sv
// Bench for triangle_normal: directed winding/collinear/overflow/backpressure/
// reset cases followed by random triangles, all checked against an integer
// cross-product model with per-stage saturation.
module tb_triangle_normal;

   localparam int     W    = 16;
   localparam int     F    = 8;
   localparam longint ONE  = 256;
   localparam longint MAXV = 32767;
   localparam longint MINV = -32768;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b1;
   logic [3*W-1:0]  v0 = '0, v1 = '0, v2 = '0;
   logic [3*W-1:0]  normal;
   logic            in_ready, out_valid, out_overflow, out_degenerate;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   triangle_normal dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .v0(v0), .v1(v1), .v2(v2),
      .out_valid(out_valid), .out_ready(out_ready),
      .normal(normal), .out_overflow(out_overflow), .out_degenerate(out_degenerate)
   );

   function automatic logic [3*W-1:0] mk(input longint x, input longint y, input longint z);
      return {x[W-1:0], y[W-1:0], z[W-1:0]};
   endfunction

   function automatic longint comp(input logic [3*W-1:0] v, input int i);
      logic signed [W-1:0] t;
      t = v[(2-i)*W +: W];
      return longint'(t);
   endfunction

   function automatic longint sat(input longint v, inout bit o);
      if (v > MAXV) begin o = 1'b1; return MAXV; end
      if (v < MINV) begin o = 1'b1; return MINV; end
      return v;
   endfunction

   function automatic longint fmul(input longint a, input longint b, inout bit o);
      return sat((a * b) >>> F, o);
   endfunction

   // Reference: edges, cross product, each stage clamped to 16-bit signed.
   task automatic model(input logic [3*W-1:0] a, input logic [3*W-1:0] b,
                        input logic [3*W-1:0] c, output logic [3*W-1:0] n,
                        output bit ovf, output bit deg);
      longint e1[3], e2[3], r[3];
      bit o = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e1[i] = sat(comp(b, i) - comp(a, i), o);
         e2[i] = sat(comp(c, i) - comp(a, i), o);
      end
      r[0] = sat(fmul(e1[1], e2[2], o) - fmul(e1[2], e2[1], o), o);
      r[1] = sat(fmul(e1[2], e2[0], o) - fmul(e1[0], e2[2], o), o);
      r[2] = sat(fmul(e1[0], e2[1], o) - fmul(e1[1], e2[0], o), o);
      n   = mk(r[0], r[1], r[2]);
      ovf = o;
      deg = (r[0] == 0) && (r[1] == 0) && (r[2] == 0) && !o;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [3*W-1:0] a, input logic [3*W-1:0] b, input logic [3*W-1:0] c);
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      in_valid = 1'b1; v0 = a; v1 = b; v2 = c;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [3*W-1:0] a,
                                input logic [3*W-1:0] b, input logic [3*W-1:0] c);
      logic [3*W-1:0] n;
      bit o, d;
      int lat;
      model(a, b, c, n, o, d);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 40);
      chk({tag, ".latency"},   64'(lat), 64'd8);
      chk({tag, ".normal"},    64'(normal), 64'(n));
      chk({tag, ".overflow"},  64'(out_overflow), 64'(o));
      chk({tag, ".degenerate"},64'(out_degenerate), 64'(d));
      if (out_ready) begin
         @(posedge clk); #1;
         chk({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
      end
   endtask

   initial begin
      logic [3*W-1:0] a, b, c, n_hold;
      logic [63:0] rr;
      logic ovf_hold, deg_hold;
      int seen;

      // ---- reset state ----
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready",   64'(in_ready), 64'd0);
      chk("rst.out_valid",  64'(out_valid), 64'd0);
      chk("rst.normal",     64'(normal), 64'd0);
      chk("rst.overflow",   64'(out_overflow), 64'd0);
      chk("rst.degenerate", 64'(out_degenerate), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst.in_ready", 64'(in_ready), 64'd1);

      // ---- winding CCW / CW, collinear, overflow ----
      a = mk(0, 0, 0); b = mk(ONE, 0, 0); c = mk(0, ONE, 0);
      send(a, b, c); expect_result("ccw", a, b, c);
      chk("ccw.z_literal", 64'(comp(mk(0, 0, ONE), 2)), 64'(ONE));
      a = mk(0, 0, 0); b = mk(0, ONE, 0); c = mk(ONE, 0, 0);
      send(a, b, c); expect_result("cw", a, b, c);
      a = mk(0, 0, 0); b = mk(ONE, ONE, ONE); c = mk(2*ONE, 2*ONE, 2*ONE);
      send(a, b, c); expect_result("collinear", a, b, c);
      a = mk(MINV, 0, 0); b = mk(MAXV, 0, 0); c = mk(0, MAXV, 0);
      send(a, b, c); expect_result("overflow", a, b, c);

      // ---- backpressure ----
      out_ready = 1'b0;
      a = mk(ONE, 2*ONE, -ONE); b = mk(3*ONE, -ONE, ONE); c = mk(-2*ONE, ONE, 4*ONE);
      send(a, b, c); expect_result("bp", a, b, c);
      n_hold = normal; ovf_hold = out_overflow; deg_hold = out_degenerate;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         rr = {$urandom, $urandom}; v0 = rr[47:0];
         rr = {$urandom, $urandom}; v1 = rr[47:0];
         rr = {$urandom, $urandom}; v2 = rr[47:0];
         @(posedge clk); #1;
         chk("bp.hold_normal",   64'(normal), 64'(n_hold));
         chk("bp.hold_flags",    64'({out_overflow, out_degenerate}), 64'({ovf_hold, deg_hold}));
         chk("bp.hold_valid",    64'(out_valid), 64'd1);
         chk("bp.in_ready_low",  64'(in_ready), 64'd0);
      end
      a = mk(0, 0, 0); b = mk(2*ONE, 0, 0); c = mk(0, 0, 3*ONE);
      in_valid = 1'b1; v0 = a; v1 = b; v2 = c; out_ready = 1'b1;
      @(posedge clk); #1;                     // transfer edge
      chk("bp.one_transfer", 64'(out_valid), 64'd0);
      chk("bp.idle_ready",   64'(in_ready), 64'd1);
      @(posedge clk); #1;                     // accept edge
      in_valid = 1'b0;
      chk("bp.accepted", 64'(in_ready), 64'd0);
      expect_result("bp_next", a, b, c);

      // ---- reset in the middle of MUL ----
      a = mk(MINV, 0, 0); b = mk(MAXV, 0, 0); c = mk(0, MAXV, 0);
      send(a, b, c);
      repeat (4) @(posedge clk);              // now in MUL with counter=3
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst.in_ready_in_rst", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("midrst.in_ready_after", 64'(in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("midrst.no_output", 64'(seen), 64'd0);
      a = mk(0, 0, 0); b = mk(ONE, 0, 0); c = mk(0, ONE, 0);
      send(a, b, c); expect_result("midrst_next", a, b, c);

      // ---- random triangles ----
      for (int t = 0; t < 16; t++) begin
         if (t % 2 == 0) begin
            a = mk(longint'($urandom_range(0, 2047)) - 1024, longint'($urandom_range(0, 2047)) - 1024,
                   longint'($urandom_range(0, 2047)) - 1024);
            b = mk(longint'($urandom_range(0, 2047)) - 1024, longint'($urandom_range(0, 2047)) - 1024,
                   longint'($urandom_range(0, 2047)) - 1024);
            c = mk(longint'($urandom_range(0, 2047)) - 1024, longint'($urandom_range(0, 2047)) - 1024,
                   longint'($urandom_range(0, 2047)) - 1024);
         end else begin
            rr = {$urandom, $urandom}; a = rr[47:0];
            rr = {$urandom, $urandom}; b = rr[47:0];
            rr = {$urandom, $urandom}; c = rr[47:0];
         end
         send(a, b, c); expect_result("rand", a, b, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
